// File: rtl/scan_coeff_sig_collector_pkg.sv
// Shared types for the RDOQ scan-side coefficient significance collector.
// Holds coefficient/scan-position types and the collector FSM states.
package rdoq_scan_pkg;

  localparam int COEF_W       = 16;
  localparam int MAX_CG       = 64;
  localparam int MAX_LOG2_BLK = 5;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic [9:0]               scan_pos_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    REPORT
  } col_state_e;

endpackage

// File: rtl/scan_coeff_sig_collector_acc.sv
// Stage-1 beat register plus last-position / CG-flag / count accumulation.
// Read data lines up with the registered beat one cycle after the read.
module sig_accumulator
  import rdoq_scan_pkg::*;
#(
  parameter int COEF_W = 16,
  parameter int MAX_CG = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              beat_i,
  input  logic [9:0]        idx_i,
  input  logic [9:0]        addr_i,
  input  logic [5:0]        cg_i,
  input  logic [COEF_W-1:0] rd_data_i,
  output logic [9:0]        last_pos_o,
  output logic [9:0]        last_addr_o,
  output logic [MAX_CG-1:0] flags_o,
  output logic [10:0]       num_sig_o
);

  logic              s1_valid_q;
  logic [9:0]        s1_idx_q;
  logic [9:0]        s1_addr_q;
  logic [5:0]        s1_cg_q;

  logic [9:0]        last_pos_q, last_pos_d;
  logic [9:0]        last_addr_q, last_addr_d;
  logic [MAX_CG-1:0] flags_q, flags_d;
  logic [10:0]       num_q, num_d;
  logic              hit;

  assign hit = s1_valid_q && (rd_data_i != '0);

  always_comb begin
    last_pos_d  = last_pos_q;
    last_addr_d = last_addr_q;
    flags_d     = flags_q;
    num_d       = num_q;
    if (clr_i) begin
      last_pos_d  = '0;
      last_addr_d = '0;
      flags_d     = '0;
      num_d       = '0;
    end else if (hit) begin
      last_pos_d       = s1_idx_q;
      last_addr_d      = s1_addr_q;
      flags_d[s1_cg_q] = 1'b1;
      num_d            = num_q + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s1_addr_q   <= '0;
      s1_cg_q     <= '0;
      last_pos_q  <= '0;
      last_addr_q <= '0;
      flags_q     <= '0;
      num_q       <= '0;
    end else begin
      s1_valid_q  <= beat_i;
      if (beat_i) begin
        s1_idx_q  <= idx_i;
        s1_addr_q <= addr_i;
        s1_cg_q   <= cg_i;
      end
      last_pos_q  <= last_pos_d;
      last_addr_q <= last_addr_d;
      flags_q     <= flags_d;
      num_q       <= num_d;
    end
  end

  assign last_pos_o  = last_pos_q;
  assign last_addr_o = last_addr_q;
  assign flags_o     = flags_q;
  assign num_sig_o   = num_q;

endmodule

// File: rtl/scan_coeff_sig_collector.sv
// Collects RDOQ pre-pass significance results over one scanned block.
// Optional scan index sequence checking: define SCAN_SEQ_CHECK_EN.
module scan_coeff_sig_collector
  import rdoq_scan_pkg::*;
#(
  parameter int COEF_W = 16,
  parameter int MAX_CG = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        log2_blk_w,
  input  logic [2:0]        log2_blk_h,
  input  logic              scan_valid,
  input  logic [9:0]        scan_index,
  input  logic [9:0]        scan_addr,
  input  logic [9:0]        scan_cg_addr,
  output logic              coef_rd_en,
  output logic [9:0]        coef_rd_addr,
  input  logic [COEF_W-1:0] coef_rd_data,
  output logic              result_valid,
  output logic [9:0]        last_scan_pos,
  output logic [9:0]        last_raster_addr,
  output logic [MAX_CG-1:0] sig_cg_flags,
  output logic [10:0]       num_sig,
  output logic              all_zero,
  output logic              busy,
  output logic              seq_err
);

  col_state_e  state_q, state_d;
  logic [10:0] total_q;
  logic        all_zero_q;
  logic        clr;
  logic        last_hit;
  logic        unused_cg;

  assign unused_cg = ^scan_cg_addr[9:6];
  assign last_hit  = scan_valid && ({1'b0, scan_index} == total_q - 11'd1);

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = COLLECT;
        end
      end
      COLLECT: if (last_hit) state_d = DRAIN;
      DRAIN:   state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      total_q    <= '0;
      all_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        total_q    <= 11'd1 << ({1'b0, log2_blk_w} + {1'b0, log2_blk_h});
        all_zero_q <= 1'b0;
      end else if (state_q == REPORT) begin
        all_zero_q <= (num_sig == '0);
      end
    end
  end

  assign coef_rd_en   = (state_q == COLLECT) && scan_valid;
  assign coef_rd_addr = coef_rd_en ? scan_addr : '0;
  assign result_valid = (state_q == REPORT);
  assign busy         = (state_q == COLLECT) || (state_q == DRAIN);
  // all_zero must be valid during the report pulse itself, then holds
  assign all_zero     = result_valid ? (num_sig == '0) : all_zero_q;

  sig_accumulator #(
    .COEF_W (COEF_W),
    .MAX_CG (MAX_CG)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .beat_i      (coef_rd_en),
    .idx_i       (scan_index),
    .addr_i      (scan_addr),
    .cg_i        (scan_cg_addr[5:0]),
    .rd_data_i   (coef_rd_data),
    .last_pos_o  (last_scan_pos),
    .last_addr_o (last_raster_addr),
    .flags_o     (sig_cg_flags),
    .num_sig_o   (num_sig)
  );

`ifdef SCAN_SEQ_CHECK_EN
  logic [9:0] exp_idx_q;
  logic       seq_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_idx_q <= '0;
      seq_err_q <= 1'b0;
    end else if (clr) begin
      exp_idx_q <= '0;
      seq_err_q <= 1'b0;
    end else if (coef_rd_en) begin
      exp_idx_q <= exp_idx_q + 10'd1;
      if (scan_index != exp_idx_q) seq_err_q <= 1'b1;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_scan_coeff_sig_collector.sv
// Self-checking bench for scan_coeff_sig_collector with a result scoreboard.
// Bench acts as the scan source and the coefficient buffer.
module tb_scan_coeff_sig_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  log2_blk_w, log2_blk_h;
  logic        scan_valid;
  logic [9:0]  scan_index, scan_addr, scan_cg_addr;
  logic        coef_rd_en;
  logic [9:0]  coef_rd_addr;
  logic [15:0] coef_rd_data;
  logic        result_valid;
  logic [9:0]  last_scan_pos, last_raster_addr;
  logic [63:0] sig_cg_flags;
  logic [10:0] num_sig;
  logic        all_zero, busy, seq_err;

  scan_coeff_sig_collector #(.COEF_W(16), .MAX_CG(64)) dut (
    .clk(clk), .rst(rst), .start(start),
    .log2_blk_w(log2_blk_w), .log2_blk_h(log2_blk_h),
    .scan_valid(scan_valid), .scan_index(scan_index),
    .scan_addr(scan_addr), .scan_cg_addr(scan_cg_addr),
    .coef_rd_en(coef_rd_en), .coef_rd_addr(coef_rd_addr),
    .coef_rd_data(coef_rd_data), .result_valid(result_valid),
    .last_scan_pos(last_scan_pos), .last_raster_addr(last_raster_addr),
    .sig_cg_flags(sig_cg_flags), .num_sig(num_sig),
    .all_zero(all_zero), .busy(busy), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [15:0] mem [1024];
  always @(posedge clk)
    coef_rd_data <= coef_rd_en ? mem[coef_rd_addr] : 16'h7fff;

  typedef struct {
    int          l2w, l2h;
    bit          diag, gaps;
    int          nz0, nz1;
    int          e_last, e_addr;
    logic [63:0] e_flags;
    int          e_num;
  } vec_t;

  typedef struct {
    logic [9:0]  last, addr;
    logic [63:0] flags;
    logic [10:0] num;
    logic        az, se;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   last_beat_cyc = 0;
  int   diag4 [16] = '{0,4,1,8,5,2,12,9,6,3,13,10,7,14,11,15};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CG-raster order with raster order inside each 4x4 CG; 4x4 diag option
  task automatic scan_at(input int l2w, input int l2h, input bit diag,
                         input int i, output int addr, output int cg);
    int w, cgi, p, cgx, cgy, x, y;
    w = 1 << l2w;
    if (diag && l2w == 2 && l2h == 2) begin
      addr = diag4[i];
      cg   = 0;
    end else begin
      cgi = i / 16;
      p   = i % 16;
      cgx = cgi % (w / 4);
      cgy = cgi / (w / 4);
      x   = cgx * 4 + p % 4;
      y   = cgy * 4 + p / 4;
      addr = y * w + x;
      cg   = cgi;
    end
  endtask

  task automatic beat(input int idx, input int addr, input int cg);
    scan_valid   = 1'b1;
    scan_index   = 10'(idx);
    scan_addr    = 10'(addr);
    scan_cg_addr = 10'(cg);
    last_beat_cyc = cyc;
    tick();
    scan_valid = 1'b0;
  endtask

  task automatic do_start(input int l2w, input int l2h);
    start = 1'b1;
    log2_blk_w = 3'(l2w);
    log2_blk_h = 3'(l2h);
    tick();
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("seq_err_clear_on_start", {63'd0, seq_err}, 64'd0);
  endtask

  task automatic wait_result();
    for (int k = 0; k < 12 && sb.size() > 0; k++) tick();
    if (sb.size() > 0) begin
      chk("result_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic run_block(input vec_t v);
    exp_t e;
    int a, c, tot;
    for (int k = 0; k < 1024; k++) mem[k] = '0;
    if (v.nz0 >= 0) mem[v.nz0] = -16'sd3;
    if (v.nz1 >= 0) mem[v.nz1] = 16'sd17;
    tot = 1 << (v.l2w + v.l2h);
    e.last  = 10'(v.e_last);
    e.addr  = 10'(v.e_addr);
    e.flags = v.e_flags;
    e.num   = 11'(v.e_num);
    e.az    = (v.e_num == 0);
    e.se    = 1'b0;
    tick();
    do_start(v.l2w, v.l2h);
    sb.push_back(e);
    for (int i = 0; i < tot; i++) begin
      if (v.gaps && i > 0 && i % 5 == 0) repeat (3) tick();
      scan_at(v.l2w, v.l2h, v.diag, i, a, c);
      beat(i, a, c);
    end
    wait_result();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && result_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_result", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("latency", 64'(cyc - last_beat_cyc), 64'd2);
        chk("last_scan_pos", 64'(last_scan_pos), 64'(e.last));
        chk("last_raster_addr", 64'(last_raster_addr), 64'(e.addr));
        chk("sig_cg_flags", sig_cg_flags, e.flags);
        chk("num_sig", 64'(num_sig), 64'(e.num));
        chk("all_zero", 64'(all_zero), 64'(e.az));
        chk("seq_err", 64'(seq_err), 64'(e.se));
      end
    end
  end

  task automatic chk_all_zero_out(input string nm);
    chk({nm, "_outs"},
        {48'd0, result_valid, last_scan_pos != 0, last_raster_addr != 0,
         sig_cg_flags != 0, num_sig != 0, all_zero, busy, seq_err,
         coef_rd_en, coef_rd_addr != 0, 6'd0}, 64'd0);
  endtask

  vec_t tv[6];

  initial begin
    int a, c;
    rst = 1'b1; start = 1'b0; scan_valid = 1'b0;
    log2_blk_w = '0; log2_blk_h = '0;
    scan_index = '0; scan_addr = '0; scan_cg_addr = '0;
    tick(); tick();
    chk_all_zero_out("reset");
    rst = 1'b0;

    tv[0] = '{2, 2, 1'b1, 1'b0, 5, -1, 4, 5, 64'h1, 1};
    tv[1] = '{3, 3, 1'b0, 1'b0, -1, -1, 0, 0, 64'h0, 0};
    tv[2] = '{5, 5, 1'b0, 1'b0, 0, 924, 1008, 924,
              64'h8000_0000_0000_0001, 2};
    tv[3] = '{3, 3, 1'b0, 1'b1, 9, 54, 58, 54, 64'h9, 2};
    tv[4] = '{3, 3, 1'b0, 1'b0, 9, 54, 58, 54, 64'h9, 2};
    tv[5] = '{4, 3, 1'b0, 1'b0, 0, 127, 127, 127, 64'h81, 2};
    for (int t = 0; t < 6; t++) run_block(tv[t]);

    // reset in the middle of a 16x16 block, every coefficient non-zero
    for (int k = 0; k < 1024; k++) mem[k] = 16'sd1;
    tick();
    do_start(4, 4);
    for (int i = 0; i < 7; i++) begin
      scan_at(4, 4, 1'b0, i, a, c);
      beat(i, a, c);
    end
    scan_at(4, 4, 1'b0, 7, a, c);
    rst = 1'b1;
    beat(7, a, c);
    rst = 1'b0;
    chk_all_zero_out("mid_reset");
    tick();
    chk_all_zero_out("post_reset_idle");
    run_block(tv[0]);

`ifdef SCAN_SEQ_CHECK_EN
    begin
      exp_t e;
      for (int k = 0; k < 1024; k++) mem[k] = '0;
      tick();
      do_start(2, 2);
      e = '{10'd0, 10'd0, 64'd0, 11'd0, 1'b1, 1'b1};
      sb.push_back(e);
      beat(0, diag4[0], 0);
      beat(1, diag4[1], 0);
      chk("seq_ok_before_skip", {63'd0, seq_err}, 64'd0);
      beat(3, diag4[3], 0);
      chk("seq_err_after_skip", {63'd0, seq_err}, 64'd1);
      for (int i = 4; i < 16; i++) beat(i, diag4[i], 0);
      wait_result();
      run_block(tv[0]);
    end
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
